if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//  Instruction-fetch front end of the 5-stage RISC-V pipeline: owns the PC register, drives the
//  instruction-memory address, and latches the IF/ID pipeline register under stall/flush control.
//  Sits between the hazard unit / ID-stage branch resolution and the decode stage.
//  Also keeps saturating stall/flush/fetch event counters, read by the top-level bench.
// PARAMETERS
//  XLEN      32  width of PC, addresses and instruction words
//  RESET_PC  0   PC value loaded on reset
//  CNT_W     32  width of each event counter
// PORTS
//  clk_i            in   1      clock; all state updates on rising edge
//  rst_i            in   1      synchronous reset, active-high
//  start_i          in   1      run enable; low = fetch frozen
//  stall_i          in   1      hazard-unit stall request (load-use)
//  flush_i          in   1      branch taken in ID; redirect and squash IF/ID
//  branch_target_i  in   XLEN   redirect address, valid when flush_i=1
//  imem_addr_o      out  XLEN   instruction-memory byte address (= pc_o)
//  imem_instr_i     in   XLEN   instruction word, combinational read of imem_addr_o
//  pc_o             out  XLEN   current PC
//  ifid_pc_o        out  XLEN   PC of the instruction held in IF/ID
//  ifid_instr_o     out  XLEN   instruction held in IF/ID
//  ifid_valid_o     out  1      1 = IF/ID holds a real instruction, 0 = bubble
//  stall_cnt_o      out  CNT_W  cycles stalled (excluding stalls coincident with flush)
//  flush_cnt_o      out  CNT_W  cycles flushed
//  fetch_cnt_o      out  CNT_W  instructions fetched into IF/ID
// BEHAVIOUR
//  - Reset (rst_i=1 at edge): pc_o=RESET_PC; ifid_pc_o=0, ifid_instr_o=0, ifid_valid_o=0;
//    all counters=0. Reset overrides every other input, including mid-stall or mid-flush.
//  - imem_addr_o = pc_o, combinational; no other combinational path to outputs.
//  - Per-edge priority when not in reset: !start_i > flush_i > stall_i > advance.
//    !start_i : PC holds; IF/ID := bubble (pc 0, instr 0, valid 0); counters hold.
//    flush_i  : PC := {branch_target_i[XLEN-1:2],2'b00}; IF/ID := bubble; flush_cnt++.
//               Concurrent stall_i is ignored and stall_cnt is not incremented.
//    stall_i  : PC holds; IF/ID holds all fields unchanged; stall_cnt++.
//    advance  : PC := PC+4 (mod 2^XLEN, wraps 0xFFFFFFFC->0); IF/ID := {pc_o, imem_instr_i, 1};
//               fetch_cnt++.
//  - Latency: the word at address A appears on ifid_instr_o one edge after pc_o=A (advance cycle).
//  - Counters saturate at all-ones; never wrap.
//  - Bubble encoding is all-zero instruction with valid=0; downstream treats it as a NOP.
//  - start_i deassert mid-run freezes the PC; reassert resumes fetch from the held PC with no skip.
// STRUCTURE
//  - Shared package cpu_pkg: XLEN, RESET_PC, PC_STEP (=4), BUBBLE_INSTR (=0) constants.
//  - Sub-module sat_counter (params CNT_W; ports clk_i, rst_i, inc_i, cnt_o), instantiated 3x.
//  - PC register and IF/ID register are in this module; no FSM beyond the priority mux.
// TESTING
//  1 Reset then start_i=1, imem = {A,B,C,...}: pc_o 0,4,8,...; ifid_instr_o A then B, valid=1; fetch_cnt 1,2,3.
//  2 stall_i=1 for 2 cycles at pc_o=8: pc_o stays 8, IF/ID holds B @ pc 4; stall_cnt=2; then resumes with C.
//  3 flush_i=1, branch_target_i=0x40 at pc_o=12: next pc_o=0x40, ifid_valid_o=0; flush_cnt=1.
//  4 flush_i=1 and stall_i=1 together, target 0x80: pc_o=0x80, bubble, flush_cnt+1, stall_cnt unchanged.
//  5 Force PC to 0xFFFFFFFC via flush target, advance: pc_o=0; target 0x43 -> pc_o=0x40.
//  6 rst_i=1 during stall with counters nonzero: next edge pc_o=0, valid=0, all counters 0; start_i=0 holds PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants for the RISC-V pipeline front end.
package cpu_pkg;

  localparam int          XLEN         = 32;
  localparam logic [31:0] RESET_PC     = 32'h0000_0000;
  localparam int          PC_STEP      = 4;
  localparam logic [31:0] BUBBLE_INSTR = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_o <= '0;
    end else if (inc_i && !(&cnt_o)) begin
      cnt_o <= cnt_o + 1'b1;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register and event counters.
module if_stage #(
  parameter int              XLEN     = cpu_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(cpu_pkg::RESET_PC),
  parameter int              CNT_W    = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic [XLEN-1:0]  branch_target_i,
  output logic [XLEN-1:0]  imem_addr_o,
  input  logic [XLEN-1:0]  imem_instr_i,
  output logic [XLEN-1:0]  pc_o,
  output logic [XLEN-1:0]  ifid_pc_o,
  output logic [XLEN-1:0]  ifid_instr_o,
  output logic             ifid_valid_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [CNT_W-1:0] fetch_cnt_o
);

  import cpu_pkg::PC_STEP;
  import cpu_pkg::BUBBLE_INSTR;

  logic [XLEN-1:0] redirect_pc;
  logic            stall_inc;
  logic            flush_inc;
  logic            fetch_inc;

  // Redirects are forced word-aligned by clearing the two low bits.
  assign redirect_pc = branch_target_i & ~XLEN'(3);

  assign flush_inc = start_i && flush_i;
  assign stall_inc = start_i && !flush_i && stall_i;
  assign fetch_inc = start_i && !flush_i && !stall_i;

  assign imem_addr_o = pc_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_o         <= RESET_PC;
      ifid_pc_o    <= '0;
      ifid_instr_o <= XLEN'(BUBBLE_INSTR);
      ifid_valid_o <= 1'b0;
    end else if (!start_i || flush_i) begin
      if (start_i) begin
        pc_o <= redirect_pc;
      end
      ifid_pc_o    <= '0;
      ifid_instr_o <= XLEN'(BUBBLE_INSTR);
      ifid_valid_o <= 1'b0;
    end else if (!stall_i) begin
      pc_o         <= pc_o + XLEN'(PC_STEP);
      ifid_pc_o    <= pc_o;
      ifid_instr_o <= imem_instr_i;
      ifid_valid_o <= 1'b1;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (stall_inc),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (flush_inc),
    .cnt_o (flush_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_fetch_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (fetch_inc),
    .cnt_o (fetch_cnt_o)
  );

endmodule

// File: tb/tb_if_stage.sv
// Directed vector bench for if_stage; a second narrow-counter instance covers saturation.
module tb_if_stage;

  logic        clk_i = 1'b0;
  logic        rst_i, start_i, stall_i, flush_i;
  logic [31:0] branch_target_i;
  logic [31:0] imem_addr_o, imem_instr_i, pc_o, ifid_pc_o, ifid_instr_o;
  logic        ifid_valid_o;
  logic [31:0] stall_cnt_o, flush_cnt_o, fetch_cnt_o;

  logic [31:0] s_addr, s_instr, s_pc, s_ifid_pc, s_ifid_instr;
  logic        s_valid;
  logic [2:0]  s_stall_cnt, s_flush_cnt, s_fetch_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  // Instruction memory: word at address A is 0x1000_0000 + A.
  assign imem_instr_i = 32'h1000_0000 + imem_addr_o;
  assign s_instr      = 32'h1000_0000 + s_addr;

  if_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stall_i(stall_i),
    .flush_i(flush_i), .branch_target_i(branch_target_i),
    .imem_addr_o(imem_addr_o), .imem_instr_i(imem_instr_i), .pc_o(pc_o),
    .ifid_pc_o(ifid_pc_o), .ifid_instr_o(ifid_instr_o), .ifid_valid_o(ifid_valid_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o), .fetch_cnt_o(fetch_cnt_o)
  );

  if_stage #(.CNT_W(3)) dut_s (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stall_i(stall_i),
    .flush_i(flush_i), .branch_target_i(branch_target_i),
    .imem_addr_o(s_addr), .imem_instr_i(s_instr), .pc_o(s_pc),
    .ifid_pc_o(s_ifid_pc), .ifid_instr_o(s_ifid_instr), .ifid_valid_o(s_valid),
    .stall_cnt_o(s_stall_cnt), .flush_cnt_o(s_flush_cnt), .fetch_cnt_o(s_fetch_cnt)
  );

  typedef struct {
    logic        rst, start, stall, flush;
    logic [31:0] tgt;
    logic [31:0] pc, ipc, instr;
    logic        valid;
    logic [31:0] sc, fc, ftc;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  function automatic vec_t mk(logic r, logic s, logic st, logic fl, logic [31:0] tg,
                              logic [31:0] pc, logic [31:0] ipc, logic [31:0] ins,
                              logic v, logic [31:0] sc, logic [31:0] fc, logic [31:0] ftc);
    vec_t x;
    x.rst = r; x.start = s; x.stall = st; x.flush = fl; x.tgt = tg;
    x.pc = pc; x.ipc = ipc; x.instr = ins; x.valid = v;
    x.sc = sc; x.fc = fc; x.ftc = ftc;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic st, input logic fl,
                      input logic [31:0] tg);
    @(negedge clk_i);
    rst_i = r; start_i = s; stall_i = st; flush_i = fl; branch_target_i = tg;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    //              rst st  stl fl  target        pc            ifid_pc       ifid_instr    v  stl fl ftc
    vecs[0]  = mk(1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 0, 0);
    vecs[2]  = mk(0, 1, 0, 0, 32'h0,        32'h4,        32'h0,        32'h1000_0000, 1, 0, 0, 1);
    vecs[3]  = mk(0, 1, 0, 0, 32'h0,        32'h8,        32'h4,        32'h1000_0004, 1, 0, 0, 2);
    vecs[4]  = mk(0, 1, 1, 0, 32'h0,        32'h8,        32'h4,        32'h1000_0004, 1, 1, 0, 2);
    vecs[5]  = mk(0, 1, 1, 0, 32'h0,        32'h8,        32'h4,        32'h1000_0004, 1, 2, 0, 2);
    vecs[6]  = mk(0, 1, 0, 0, 32'h0,        32'hC,        32'h8,        32'h1000_0008, 1, 2, 0, 3);
    vecs[7]  = mk(0, 1, 0, 1, 32'h40,       32'h40,       32'h0,        32'h0,        0, 2, 1, 3);
    vecs[8]  = mk(0, 1, 0, 0, 32'h0,        32'h44,       32'h40,       32'h1000_0040, 1, 2, 1, 4);
    vecs[9]  = mk(0, 1, 1, 1, 32'h80,       32'h80,       32'h0,        32'h0,        0, 2, 2, 4);
    vecs[10] = mk(0, 1, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0,      32'h0,        0, 2, 3, 4);
    vecs[11] = mk(0, 1, 0, 0, 32'h0,        32'h0,        32'hFFFF_FFFC, 32'h0FFF_FFFC, 1, 2, 3, 5);
    vecs[12] = mk(0, 1, 0, 1, 32'h43,       32'h40,       32'h0,        32'h0,        0, 2, 4, 5);
    vecs[13] = mk(0, 1, 0, 0, 32'h0,        32'h44,       32'h40,       32'h1000_0040, 1, 2, 4, 6);
    vecs[14] = mk(0, 1, 1, 0, 32'h0,        32'h44,       32'h40,       32'h1000_0040, 1, 3, 4, 6);
    vecs[15] = mk(1, 1, 1, 0, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 0, 0);
    vecs[16] = mk(0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 0, 0);
    vecs[17] = mk(0, 0, 1, 0, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 0, 0);
    vecs[18] = mk(0, 1, 0, 0, 32'h0,        32'h4,        32'h0,        32'h1000_0000, 1, 0, 0, 1);
    vecs[19] = mk(0, 0, 0, 0, 32'h0,        32'h4,        32'h0,        32'h0,        0, 0, 0, 1);
    vecs[20] = mk(0, 1, 0, 0, 32'h0,        32'h8,        32'h4,        32'h1000_0004, 1, 0, 0, 2);
    vecs[21] = mk(0, 0, 0, 1, 32'h80,       32'h8,        32'h0,        32'h0,        0, 0, 0, 2);

    rst_i = 1'b1; start_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0; branch_target_i = '0;

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].rst, vecs[i].start, vecs[i].stall, vecs[i].flush, vecs[i].tgt);
      check($sformatf("v%0d pc", i),        pc_o,         vecs[i].pc);
      check($sformatf("v%0d imem_addr", i), imem_addr_o,  vecs[i].pc);
      check($sformatf("v%0d ifid_pc", i),   ifid_pc_o,    vecs[i].ipc);
      check($sformatf("v%0d ifid_instr", i), ifid_instr_o, vecs[i].instr);
      check($sformatf("v%0d ifid_valid", i), {31'b0, ifid_valid_o}, {31'b0, vecs[i].valid});
      check($sformatf("v%0d stall_cnt", i), stall_cnt_o,  vecs[i].sc);
      check($sformatf("v%0d flush_cnt", i), flush_cnt_o,  vecs[i].fc);
      check($sformatf("v%0d fetch_cnt", i), fetch_cnt_o,  vecs[i].ftc);
    end

    // Saturation: narrow instance sticks at 7 while the wide one keeps counting.
    for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 32'h0);
    check("sat fetch wide",   fetch_cnt_o, 32'd10);
    check("sat fetch narrow", {29'b0, s_fetch_cnt}, 32'd7);
    check("sat pc wide",      pc_o, 32'h28);
    check("sat pc narrow",    s_pc, 32'h28);
    for (int i = 0; i < 9; i++) step(0, 1, 1, 0, 32'h0);
    check("sat stall wide",   stall_cnt_o, 32'd9);
    check("sat stall narrow", {29'b0, s_stall_cnt}, 32'd7);
    check("sat fetch hold",   {29'b0, s_fetch_cnt}, 32'd7);
    for (int i = 0; i < 9; i++) step(0, 1, 0, 1, 32'h100);
    check("sat flush wide",   flush_cnt_o, 32'd9);
    check("sat flush narrow", {29'b0, s_flush_cnt}, 32'd7);
    check("sat stall hold",   {29'b0, s_stall_cnt}, 32'd7);
    check("flush pc",         pc_o, 32'h100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
